shutdown_sequencer: RTL
=======================

SHUTDOWN_SEQUENCER -- requirements
Module: shutdown_sequencer

Interface
REQ-001 SHALL have parameter STAGE_DLY, default 16: cycles between successive channel enable/disable steps (legal range 1..65535).
REQ-002 SHALL have parameter FB_TIMEOUT, default 64: maximum cycles allowed for all channel feedbacks to confirm de-energized (legal range 1..65535).
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port trip, input, 1: level trip request from the ESD core (E-STOP A/B, watchdog); 1 = shutdown required.
REQ-006 SHALL have port ack_pulse, input, 1: debounced single-cycle operator ACK.
REQ-007 SHALL have port fb, input, 4: per-channel feedback; 1 = channel confirmed de-energized.
REQ-008 SHALL have port en, output, 4: per-channel energize enables; 1 = energized.
REQ-009 SHALL have port shutdown, output, 1: 1 whenever state is not RUN.
REQ-010 SHALL have port busy, output, 1: 1 in STARTUP, SHUTDOWN or VERIFY.
REQ-011 SHALL have port fault, output, 1: 1 in FAULT.
REQ-012 SHALL have port state, output, 3: encoding SAFE=0, STARTUP=1, RUN=2, SHUTDOWN=3, VERIFY=4, FAULT=5.

Function
REQ-013 SHALL implement states SAFE, STARTUP, RUN, SHUTDOWN, VERIFY, FAULT; all outputs registered.
REQ-014 SAFE: en=0; ack_pulse=1 with trip=0 and fb=4'hF -> STARTUP; otherwise stay.
REQ-015 STARTUP: en[0] set the cycle after entry; en[1], en[2], en[3] each set STAGE_DLY cycles after the previous; STAGE_DLY cycles after en[3] set -> RUN.
REQ-016 RUN: en=4'hF; trip=1 or any fb bit=1 -> SHUTDOWN; ack_pulse ignored.
REQ-017 trip=1 in STARTUP -> SHUTDOWN on the next cycle; already-cleared channels remain 0.
REQ-018 SHUTDOWN: en[3] cleared the cycle after entry; en[2], en[1], en[0] each cleared STAGE_DLY cycles after the previous; the cycle en[0] clears -> VERIFY.
REQ-019 VERIFY: fb=4'hF within FB_TIMEOUT cycles of entry -> SAFE; counter reaching FB_TIMEOUT with fb!=4'hF -> FAULT.
REQ-020 FAULT: en=0; exit to SAFE only on ack_pulse=1 with trip=0 and fb=4'hF.
REQ-021 trip and ack_pulse in the same cycle: trip takes priority; ack is discarded.
REQ-022 trip deasserting mid-SHUTDOWN SHALL NOT abort the sequence; once started, the shutdown completes.
REQ-023 Stage/timeout counter SHALL be 16 bits, reload to 0 on every state change, never wrap (saturate).

Reset
REQ-024 rst_n=0 at a clock edge SHALL force state=SAFE, en=0, shutdown=1, busy=0, fault=0, counter=0, in any state, including mid-sequence.
REQ-025 Outputs SHALL hold the reset values until the first ack_pulse after rst_n=1 (the block never energizes automatically on power-up).

Structure
REQ-026 State encoding constants and channel count (4) SHALL live in shared package esd_pkg.
REQ-027 Stage timing SHALL be a sub-module stage_timer (load/clear, count, done at programmed terminal value), reused for STAGE_DLY and FB_TIMEOUT.

Verification (STAGE_DLY=4, FB_TIMEOUT=8)
REQ-028 Reset, fb=4'hF, no ack for 100 cycles -> state=0, en=0, shutdown=1 throughout.
REQ-029 ack_pulse in SAFE, fb driven 0 after each enable -> en steps 1,3,7,F at cycles +1,+5,+9,+13; state=2 at +17; shutdown=0.
REQ-030 In RUN, trip=1 for 1 cycle -> en steps 7,3,1,0 at +1,+5,+9,+13; fb=4'hF at +15 -> state=0.
REQ-031 In VERIFY, fb held 4'h7 -> state=5, fault=1 after 8 cycles; ack with trip=1 -> stays FAULT; ack with trip=0, fb=4'hF -> SAFE.
REQ-032 trip=1 during STARTUP at en=3 -> next cycle state=3, en goes 3,1,0 over the following stages, with no bit ever re-set.
REQ-033 rst_n=0 mid-SHUTDOWN with en=3 -> next edge en=0, state=0, busy=0.

Source files
------------

// File: rtl/esd_pkg.sv
// Shared constants and state encoding for the emergency-shutdown sequencer.
package esd_pkg;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;

  typedef enum logic [2:0] {
    ST_SAFE     = 3'd0,
    ST_STARTUP  = 3'd1,
    ST_RUN      = 3'd2,
    ST_SHUTDOWN = 3'd3,
    ST_VERIFY   = 3'd4,
    ST_FAULT    = 3'd5
  } state_t;

  // Timer terminal value: done asserts on the N-th cycle after a clear.
  function automatic logic [CNT_W-1:0] term_of(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/stage_timer.sv
// Saturating up-counter with synchronous clear and a programmable terminal compare.
module stage_timer
  import esd_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic [W-1:0] term_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q != {W{1'b1}}) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q >= term_i);

endmodule

// File: rtl/shutdown_sequencer.sv
// Staged energize/de-energize sequencer for four ESD output channels with
// feedback verification and latched fault requiring operator acknowledge.
module shutdown_sequencer
  import esd_pkg::*;
#(
  parameter int STAGE_DLY  = 16,
  parameter int FB_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trip,
  input  logic              ack_pulse,
  input  logic [NUM_CH-1:0] fb,
  output logic [NUM_CH-1:0] en,
  output logic              shutdown,
  output logic              busy,
  output logic              fault,
  output logic [2:0]        state
);

  localparam logic [CNT_W-1:0] STG_TERM = term_of(STAGE_DLY);
  localparam logic [CNT_W-1:0] FB_TERM  = term_of(FB_TIMEOUT);

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] en_q, en_d;
  logic [2:0]        step_q, step_d;
  logic              sd_q, sd_d;
  logic              busy_q, busy_d;
  logic              fault_q, fault_d;
  logic              tmr_clr, tmr_done;
  logic [CNT_W-1:0]  tmr_term;
  logic              fire;
  logic              fb_all, fb_any, rearm;
  logic [1:0]        dn_idx;

  assign fb_all   = &fb;
  assign fb_any   = |fb;
  assign rearm    = ack_pulse && !trip && fb_all;
  // First step of a sequence happens immediately; later steps wait for the timer.
  assign fire     = (step_q == 3'd0) || tmr_done;
  assign dn_idx   = 2'd3 - step_q[1:0];
  assign tmr_term = (state_q == ST_VERIFY) ? FB_TERM : STG_TERM;
  assign tmr_clr  = (state_d != state_q) || (step_d != step_q);

  stage_timer #(.W(CNT_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (tmr_clr),
    .term_i (tmr_term),
    .done_o (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_SAFE;
      en_q    <= '0;
      step_q  <= '0;
      sd_q    <= 1'b1;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      step_q  <= step_d;
      sd_q    <= sd_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    step_d  = step_q;
    case (state_q)
      ST_SAFE: begin
        en_d = '0;
        if (rearm) state_d = ST_STARTUP;
      end
      ST_STARTUP: begin
        if (trip) begin
          state_d = ST_SHUTDOWN;
        end else if (fire) begin
          if (step_q == 3'd4) begin
            state_d = ST_RUN;
          end else begin
            en_d[step_q[1:0]] = 1'b1;
            step_d            = step_q + 3'd1;
          end
        end
      end
      ST_RUN: begin
        en_d = '1;
        if (trip || fb_any) state_d = ST_SHUTDOWN;
      end
      // Trip is not consulted here: a started shutdown always runs to completion.
      ST_SHUTDOWN: begin
        if (fire) begin
          en_d[dn_idx] = 1'b0;
          step_d       = step_q + 3'd1;
          if (step_q == 3'd3) state_d = ST_VERIFY;
        end
      end
      ST_VERIFY: begin
        en_d = '0;
        if (fb_all) begin
          state_d = ST_SAFE;
        end else if (tmr_done) begin
          state_d = ST_FAULT;
        end
      end
      ST_FAULT: begin
        en_d = '0;
        if (rearm) state_d = ST_SAFE;
      end
      default: begin
        state_d = ST_SAFE;
        en_d    = '0;
      end
    endcase
    if (state_d != state_q) step_d = '0;
  end

  always_comb begin
    sd_d    = (state_d != ST_RUN);
    busy_d  = (state_d == ST_STARTUP) || (state_d == ST_SHUTDOWN) || (state_d == ST_VERIFY);
    fault_d = (state_d == ST_FAULT);
  end

  assign en       = en_q;
  assign shutdown = sd_q;
  assign busy     = busy_q;
  assign fault    = fault_q;
  assign state    = state_q;

endmodule
